fcb_readback: RTL and testbench
===============================

Name: fcb_readback

Overview:
Receive end of the fabric configuration chain: serial bits leaving the chain on fpga_tail are deserialized into 32-bit words and buffered in a small FIFO. Software drains the FIFO over the same Wishbone register slave style used by the configuration block. A running checksum and bit count allow software to verify the bitstream that was shifted through the fabric. Sits beside the configuration shifter and sees the same shift strobe.

Parameters:
FIFO_DEPTH, 4, readback words buffered (power of two, >=2)
MAX_BITS, 2034, hard cap on captured bits regardless of LENGTH register

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low
wb_address  in  3  register select
wb_data_in  in  32  write data
wb_select  in  4  byte enables for writes
wb_stb  in  1  strobe
wb_we  in  1  write enable
wb_bus_cycle  in  1  cycle valid
wb_ack  out  1  one-cycle acknowledge
wb_data_out  out  32  registered read data
fpga_tail  in  1  serial bit from the end of the chain
shift_en  in  1  one-cycle strobe: one chain shift occurred, fpga_tail valid this cycle
irq  out  1  level: (word available & IRQ_EN) | (done & IRQ_EN)

Behaviour:
- Reset: state IDLE; all registers, counters and FIFO pointers 0; wb_ack=0, wb_data_out=0, irq=0.
- Register map (address): 0 CTRL, byte-enabled RW: bit0 ENABLE, bit1 CLEAR (self-clearing), bit2 IRQ_EN. 1 LENGTH, RW, expected bit count. 2 DATA, RO, read pops FIFO. 3 STATUS, RO: bit0 not_empty, bit1 full, bit2 done, bit3 overflow (sticky), bit4 checksum_match, bits[15:8] FIFO level. 4 CHECKSUM, RO. 5 EXPECTED, RW. 6 BITCOUNT, RO. 7 reads 0.
- Wishbone: an access is wb_stb & wb_bus_cycle & ~wb_ack; wb_ack asserts the next cycle for exactly one cycle; wb_data_out is valid with wb_ack, otherwise 0. Writes to RO addresses are ignored but still acknowledged.
- DATA read when the FIFO is empty: returns 0, no pop, no error. Exactly one pop per acknowledged read.
- CLEAR: FIFO, shift register, bit/word counters, checksum, done and overflow are cleared in one cycle; state returns to IDLE; CTRL/LENGTH/EXPECTED are kept.
- FSM:
  - IDLE: ENABLE=1 and LENGTH!=0 -> CAPTURE.
  - CAPTURE, on each shift_en: fpga_tail goes into bit[bit_in_word], LSB first (first bit lands in bit0). bit_in_word and BITCOUNT increment. When bit_in_word reaches 31, the word is pushed to the FIFO, CHECKSUM += word (mod 2^32), and bit_in_word wraps to 0.
  - Limit: limit = min(LENGTH, MAX_BITS). When BITCOUNT reaches limit with bit_in_word!=0 -> FLUSH; with bit_in_word==0 -> DONE.
  - FLUSH, one cycle: push the partial word zero-padded in the upper bits, add it to CHECKSUM, -> DONE.
  - DONE: done=1; shift_en ignored; ENABLE=0 -> IDLE (counters kept until CLEAR).
  - ENABLE falling during CAPTURE: -> IDLE immediately; the partial word is discarded; counters kept.
- Push while full: the word is dropped and overflow is set, but CHECKSUM still accumulates it. A push and a pop in the same cycle while full is legal: level is unchanged and no overflow.
- checksum_match = done & (CHECKSUM == EXPECTED), combinational from registers.
- shift_en while in IDLE: ignored.

Decomposition:
- Package fcb_readback_pkg: register address constants, CTRL/STATUS bit positions, FSM state encoding (IDLE, CAPTURE, FLUSH, DONE).
- Sub-module readback_fifo: synchronous single-clock FIFO, 32-bit wide, FIFO_DEPTH entries.
  - Ports: push, pop, din, dout, level, full, empty.
  - Simultaneous push/pop supported.

Test Plan:
- LENGTH=64, ENABLE=1, 64 strobes with tail pattern 0xA5A5A5A5 then 0x0000FFFF (LSB first) -> two DATA reads return 0xA5A5A5A5, 0x0000FFFF; CHECKSUM=0xA5A6A5A4; done=1.
- LENGTH=40, 40 strobes all ones -> words 0xFFFFFFFF and 0x000000FF; BITCOUNT=40; STATUS level goes 2 -> 0 after two reads.
- FIFO_DEPTH=4, LENGTH=192, no reads -> after word 5, overflow=1 and level=4; CHECKSUM includes all 6 words.
- EXPECTED set to the correct sum then to sum+1 -> checksum_match 1 then 0; CLEAR -> STATUS=0, BITCOUNT=0.
- ENABLE dropped after 20 bits, then re-enabled -> no partial word pushed; BITCOUNT stays 20 until CLEAR.
- Reset asserted mid-CAPTURE, and DATA read when empty -> all outputs 0, state IDLE; empty read returns 0 with a single-cycle wb_ack.

Source files
------------

// File: rtl/fcb_readback_pkg.sv
// Shared definitions for the configuration-chain readback block:
// register map, control/status bit positions and FSM encoding.
package fcb_readback_pkg;

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_LENGTH   = 3'd1;
  localparam logic [2:0] ADDR_DATA     = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_CHECKSUM = 3'd4;
  localparam logic [2:0] ADDR_EXPECTED = 3'd5;
  localparam logic [2:0] ADDR_BITCOUNT = 3'd6;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_DONE      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_MATCH     = 4;

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_CAPTURE,
    STATE_FLUSH,
    STATE_DONE
  } state_e;

  // Merge write data into a register under the Wishbone byte enables.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = sel[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/fcb_readback_if.sv
// Wishbone register-slave bus shared with the configuration block.
interface fcb_readback_if;
  logic [2:0]  wb_address;
  logic [31:0] wb_data_in;
  logic [3:0]  wb_select;
  logic        wb_stb;
  logic        wb_we;
  logic        wb_bus_cycle;
  logic        wb_ack;
  logic [31:0] wb_data_out;

  modport master (
    output wb_address, wb_data_in, wb_select, wb_stb, wb_we, wb_bus_cycle,
    input  wb_ack, wb_data_out
  );

  modport slave (
    input  wb_address, wb_data_in, wb_select, wb_stb, wb_we, wb_bus_cycle,
    output wb_ack, wb_data_out
  );
endinterface

// File: rtl/fcb_readback_fifo.sv
// Single-clock word FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle, since the head slot frees up at that edge.
module fcb_readback_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fcb_readback.sv
// Readback end of the fabric configuration chain: deserializes fpga_tail
// into words, buffers them and keeps a checksum/bit count for software.
module fcb_readback
  import fcb_readback_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BITS   = 2034
) (
  input  logic          clk,
  input  logic          reset,
  fcb_readback_if.slave wb,
  input  logic          fpga_tail,
  input  logic          shift_en,
  output logic          irq
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(MAX_BITS + 1);

  state_e            state, state_next;
  logic              enable, irq_en;
  logic [31:0]       length_q, expected_q, checksum_q, shift_q;
  logic [CNT_W-1:0]  bit_count;
  logic [4:0]        bit_in_word;
  logic              done_q, overflow_q;

  logic              access, wr_access, rd_access, clear;
  logic              shifting, push, pop;
  logic [31:0]       push_word, word_next, limit, count_ext, rdata;
  logic [31:0]       fifo_dout;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_full, fifo_empty, match;

  assign access    = wb.wb_stb & wb.wb_bus_cycle & ~wb.wb_ack;
  assign wr_access = access & wb.wb_we;
  assign rd_access = access & ~wb.wb_we;
  assign clear     = wr_access && (wb.wb_address == ADDR_CTRL) &&
                     wb.wb_select[0] && wb.wb_data_in[CTRL_CLEAR];
  assign pop       = rd_access && (wb.wb_address == ADDR_DATA) && !fifo_empty;

  assign limit     = (length_q < 32'(MAX_BITS)) ? length_q : 32'(MAX_BITS);
  assign count_ext = 32'(bit_count);
  assign word_next = shift_q | (32'(fpga_tail) << bit_in_word);
  assign match     = done_q && (checksum_q == expected_q);
  assign irq       = irq_en & (~fifo_empty | done_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= STATE_IDLE;
    else        state <= state_next;
  end

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path can leave a signal unassigned (no latches).
  always_comb begin
    state_next = state;
    shifting   = 1'b0;
    push       = 1'b0;
    push_word  = shift_q;
    unique case (state)
      STATE_IDLE:
        if (enable && length_q != '0) state_next = STATE_CAPTURE;
      STATE_CAPTURE: begin
        if (!enable)                state_next = STATE_IDLE;
        else if (count_ext >= limit) state_next = STATE_DONE;
        else if (shift_en) begin
          shifting = 1'b1;
          if (bit_in_word == 5'd31) begin
            push      = 1'b1;
            push_word = word_next;
          end
          if (count_ext + 32'd1 == limit)
            state_next = (bit_in_word == 5'd31) ? STATE_DONE : STATE_FLUSH;
        end
      end
      STATE_FLUSH: begin
        push       = 1'b1;
        state_next = STATE_DONE;
      end
      STATE_DONE:
        if (!enable) state_next = STATE_IDLE;
      default: state_next = STATE_IDLE;
    endcase
    if (clear) state_next = STATE_IDLE;
  end

  // Capture datapath; clear has priority over anything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || clear) begin
      shift_q     <= '0;
      bit_in_word <= '0;
      bit_count   <= '0;
      checksum_q  <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (shifting) begin
        bit_count   <= bit_count + 1'b1;
        bit_in_word <= bit_in_word + 1'b1;
        shift_q     <= (bit_in_word == 5'd31) ? '0 : word_next;
      end
      // Flushed or abandoned partial words restart word assembly at bit 0.
      if (state == STATE_FLUSH || (state == STATE_CAPTURE && !enable)) begin
        shift_q     <= '0;
        bit_in_word <= '0;
      end
      if (push)                             checksum_q <= checksum_q + push_word;
      if (push && fifo_full && !pop)        overflow_q <= 1'b1;
      if (state_next == STATE_DONE)         done_q     <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable     <= 1'b0;
      irq_en     <= 1'b0;
      length_q   <= '0;
      expected_q <= '0;
    end else if (wr_access) begin
      unique case (wb.wb_address)
        ADDR_CTRL: if (wb.wb_select[0]) begin
          enable <= wb.wb_data_in[CTRL_ENABLE];
          irq_en <= wb.wb_data_in[CTRL_IRQ_EN];
        end
        ADDR_LENGTH:   length_q   <= be_merge(length_q, wb.wb_data_in, wb.wb_select);
        ADDR_EXPECTED: expected_q <= be_merge(expected_q, wb.wb_data_in, wb.wb_select);
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    unique case (wb.wb_address)
      ADDR_CTRL:     rdata = {29'd0, irq_en, 1'b0, enable};
      ADDR_LENGTH:   rdata = length_q;
      ADDR_DATA:     rdata = fifo_empty ? '0 : fifo_dout;
      ADDR_STATUS:   rdata = {16'd0, 8'(fifo_level), 3'd0, match, overflow_q,
                              done_q, fifo_full, ~fifo_empty};
      ADDR_CHECKSUM: rdata = checksum_q;
      ADDR_EXPECTED: rdata = expected_q;
      ADDR_BITCOUNT: rdata = count_ext;
      default:       rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb.wb_ack      <= 1'b0;
      wb.wb_data_out <= '0;
    end else begin
      wb.wb_ack      <= access;
      wb.wb_data_out <= rd_access ? rdata : '0;
    end
  end

  fcb_readback_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (push_word),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_fcb_readback.sv
// Directed bench for fcb_readback: register access, word capture, flush,
// FIFO overflow, checksum match, enable abort, clear and reset.
module tb_fcb_readback;
  import fcb_readback_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic fpga_tail = 1'b0;
  logic shift_en = 1'b0;
  logic irq;
  int   n_asserts = 0;
  int   n_fails = 0;
  logic [31:0] rd;

  fcb_readback_if bus ();

  fcb_readback #(.FIFO_DEPTH(4), .MAX_BITS(2034)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb        (bus.slave),
    .fpga_tail (fpga_tail),
    .shift_en  (shift_en),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no end of test, required end before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_access(input logic [2:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [3:0] sel, output logic [31:0] rdata);
    logic got;
    got   = 1'b0;
    rdata = '0;
    @(negedge clk);
    bus.wb_address   = addr;
    bus.wb_we        = we;
    bus.wb_data_in   = wdata;
    bus.wb_select    = sel;
    bus.wb_stb       = 1'b1;
    bus.wb_bus_cycle = 1'b1;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      if (bus.wb_ack === 1'b1) begin
        got   = 1'b1;
        rdata = bus.wb_data_out;
      end
    end
    bus.wb_stb       = 1'b0;
    bus.wb_bus_cycle = 1'b0;
    bus.wb_we        = 1'b0;
    check("wb_ack_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic wb_write(input logic [2:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel = 4'hF);
    logic [31:0] dummy;
    wb_access(addr, 1'b1, wdata, sel, dummy);
  endtask

  task automatic wb_read(input logic [2:0] addr, output logic [31:0] rdata);
    wb_access(addr, 1'b0, 32'd0, 4'hF, rdata);
  endtask

  // Starts on a falling edge; one tail bit per cycle, LSB first.
  task automatic shift_bits(input logic [31:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      shift_en  = 1'b1;
      fpga_tail = word[i];
      @(negedge clk);
    end
    shift_en  = 1'b0;
    fpga_tail = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.wb_address   = '0;
    bus.wb_data_in   = '0;
    bus.wb_select    = '0;
    bus.wb_stb       = 1'b0;
    bus.wb_we        = 1'b0;
    bus.wb_bus_cycle = 1'b0;

    // Reset state
    idle(2);
    check("rst_ack", {31'd0, bus.wb_ack}, 32'd0);
    check("rst_dout", bus.wb_data_out, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    idle(1);
    wb_read(ADDR_STATUS, rd);   check("rst_status", rd, 32'd0);
    wb_read(ADDR_BITCOUNT, rd); check("rst_bitcount", rd, 32'd0);
    wb_read(3'd7, rd);          check("addr7_zero", rd, 32'd0);

    // Byte enables: CTRL write with no lanes selected changes nothing
    wb_write(ADDR_CTRL, 32'h5, 4'h0);
    wb_read(ADDR_CTRL, rd);     check("ctrl_no_lanes", rd, 32'd0);

    // Two full words, LENGTH=64
    wb_write(ADDR_LENGTH, 32'd64);
    wb_write(ADDR_CTRL, 32'h1);
    idle(2);
    shift_bits(32'hA5A5A5A5, 32);
    shift_bits(32'h0000FFFF, 32);
    idle(3);
    wb_read(ADDR_STATUS, rd);   check("a_status", rd, 32'h0000_0205);
    wb_read(ADDR_CHECKSUM, rd); check("a_checksum", rd, 32'hA5A6A5A4);
    wb_read(ADDR_BITCOUNT, rd); check("a_bitcount", rd, 32'd64);
    wb_write(ADDR_CHECKSUM, 32'hDEADBEEF);
    wb_read(ADDR_CHECKSUM, rd); check("a_ro_write_ignored", rd, 32'hA5A6A5A4);
    wb_read(ADDR_DATA, rd);     check("a_word0", rd, 32'hA5A5A5A5);
    wb_read(ADDR_DATA, rd);     check("a_word1", rd, 32'h0000FFFF);
    wb_read(ADDR_STATUS, rd);   check("a_status_drained", rd, 32'h0000_0004);

    // Checksum match against EXPECTED, then clear
    wb_write(ADDR_EXPECTED, 32'hA5A6A5A4);
    wb_read(ADDR_STATUS, rd);   check("match_on", rd, 32'h0000_0014);
    wb_write(ADDR_EXPECTED, 32'hA5A6A5A5);
    wb_read(ADDR_STATUS, rd);   check("match_off", rd, 32'h0000_0004);
    wb_write(ADDR_CTRL, 32'h2);
    wb_read(ADDR_STATUS, rd);   check("clr_status", rd, 32'd0);
    wb_read(ADDR_BITCOUNT, rd); check("clr_bitcount", rd, 32'd0);
    wb_read(ADDR_CHECKSUM, rd); check("clr_checksum", rd, 32'd0);
    wb_read(ADDR_EXPECTED, rd); check("clr_keeps_expected", rd, 32'hA5A6A5A5);

    // LENGTH=40 all ones: one full word plus a flushed partial word
    wb_write(ADDR_LENGTH, 32'd40);
    wb_write(ADDR_CTRL, 32'h5);
    idle(2);
    shift_bits(32'hFFFFFFFF, 32);
    shift_bits(32'hFFFFFFFF, 8);
    idle(3);
    check("b_irq", {31'd0, irq}, 32'd1);
    wb_read(ADDR_STATUS, rd);   check("b_status_lvl2", rd, 32'h0000_0205);
    wb_read(ADDR_BITCOUNT, rd); check("b_bitcount", rd, 32'd40);
    wb_read(ADDR_CHECKSUM, rd); check("b_checksum", rd, 32'h000000FE);
    wb_read(ADDR_DATA, rd);     check("b_word0", rd, 32'hFFFFFFFF);
    wb_read(ADDR_STATUS, rd);   check("b_status_lvl1", rd, 32'h0000_0105);
    wb_read(ADDR_DATA, rd);     check("b_word1", rd, 32'h000000FF);
    wb_read(ADDR_STATUS, rd);   check("b_status_lvl0", rd, 32'h0000_0004);
    wb_write(ADDR_CTRL, 32'h2);
    check("b_irq_off", {31'd0, irq}, 32'd0);

    // Overflow: six words into a four-entry FIFO, no reads while shifting
    wb_write(ADDR_LENGTH, 32'd192);
    wb_write(ADDR_CTRL, 32'h1);
    idle(2);
    for (int w = 1; w <= 5; w++) shift_bits(32'h11111111 * w, 32);
    idle(1);
    wb_read(ADDR_STATUS, rd);   check("c_status_after5", rd, 32'h0000_040B);
    idle(1);
    shift_bits(32'h66666666, 32);
    idle(3);
    wb_read(ADDR_STATUS, rd);   check("c_status_after6", rd, 32'h0000_040F);
    wb_read(ADDR_CHECKSUM, rd); check("c_checksum", rd, 32'h66666665);
    wb_read(ADDR_DATA, rd);     check("c_word0", rd, 32'h11111111);
    wb_read(ADDR_STATUS, rd);   check("c_status_pop", rd, 32'h0000_030D);
    wb_write(ADDR_CTRL, 32'h2);
    wb_read(ADDR_STATUS, rd);   check("c_clr_status", rd, 32'd0);

    // ENABLE dropped mid-word: partial word discarded, count kept
    wb_write(ADDR_LENGTH, 32'd64);
    wb_write(ADDR_CTRL, 32'h1);
    idle(2);
    shift_bits(32'h000FFFFF, 20);
    wb_write(ADDR_CTRL, 32'h0);
    idle(2);
    wb_read(ADDR_BITCOUNT, rd); check("d_bitcount_abort", rd, 32'd20);
    wb_write(ADDR_CTRL, 32'h1);
    idle(4);
    wb_read(ADDR_STATUS, rd);   check("d_status_reenable", rd, 32'd0);
    wb_read(ADDR_BITCOUNT, rd); check("d_bitcount_kept", rd, 32'd20);
    wb_read(ADDR_CHECKSUM, rd); check("d_checksum", rd, 32'd0);
    wb_write(ADDR_CTRL, 32'h2);
    wb_read(ADDR_BITCOUNT, rd); check("d_bitcount_clr", rd, 32'd0);

    // Reset asserted mid-capture
    wb_write(ADDR_CTRL, 32'h5);
    idle(2);
    shift_bits(32'h12345678, 32);
    shift_bits(32'h0000000F, 8);
    check("e_irq_before", {31'd0, irq}, 32'd1);
    reset = 1'b0;
    #1;
    check("e_rst_irq", {31'd0, irq}, 32'd0);
    check("e_rst_ack", {31'd0, bus.wb_ack}, 32'd0);
    check("e_rst_dout", bus.wb_data_out, 32'd0);
    idle(1);
    reset = 1'b1;
    idle(1);
    wb_read(ADDR_CTRL, rd);     check("e_ctrl", rd, 32'd0);
    wb_read(ADDR_LENGTH, rd);   check("e_length", rd, 32'd0);
    shift_bits(32'hFFFFFFFF, 4);
    wb_read(ADDR_BITCOUNT, rd); check("e_idle_ignores_shift", rd, 32'd0);
    wb_read(ADDR_STATUS, rd);   check("e_status", rd, 32'd0);

    // Empty DATA read: zero data, single-cycle acknowledge
    wb_read(ADDR_DATA, rd);     check("empty_read", rd, 32'd0);
    idle(1);
    check("empty_ack_single", {31'd0, bus.wb_ack}, 32'd0);
    wb_read(ADDR_STATUS, rd);   check("empty_no_change", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule
